uart_rx_fsm: RTL and testbench

Parametrised UART receive controller, the successor to the fixed 8N1 receive sequencer. It oversamples the serial line and validates the start bit at mid-bit. It assembles DATA_W data bits LSB-first, checks optional parity and 1 or 2 stop bits, and presents each frame with one-cycle strobe and error flags. It sits between the baud-tick generator and the UART RX FIFO/register interface.

---
 rtl/uart_rx_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// Oversampling UART receiver: mid-bit start validation, LSB-first data,
// optional odd/even parity, 1 or 2 stop bits, one-cycle frame strobe.
//
// state    | meaning
// S_IDLE   | line idle, waiting for rx_s low
// S_START  | timing to mid start bit, rejects glitches
// S_DATA   | sampling DATA_W data bits, one per OVS ticks
// S_PARITY | sampling the parity bit
// S_STOP   | sampling STOP_BITS stop bits
// S_DONE   | one-cycle frame strobe, outputs just loaded
// S_BREAK  | last stop bit was low, wait for the line to return high
module uart_rx_fsm #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx,
  input  logic              i_tick,
  output logic [DATA_W-1:0] o_data,
  output logic              o_rcv,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int TCW = $clog2(OVS);
  localparam int BCW = $clog2(DATA_W + 1);

  localparam logic [TCW-1:0] TICK_MID = TCW'(OVS / 2 - 1);
  localparam logic [TCW-1:0] TICK_END = TCW'(OVS - 1);
  localparam logic [BCW-1:0] BIT_END  = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] STOP_END = BCW'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_rx_fsm: DATA_W must be in 5..9");
  end
  if (OVS < 8 || OVS > 32 || (OVS % 2) != 0) begin : g_bad_ovs
    $error("uart_rx_fsm: OVS must be even and in 8..32");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_fsm: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_fsm: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q;
  logic                rx_s_q;
  logic [TCW-1:0]      tick_q, tick_d;
  logic [BCW-1:0]      bit_q, bit_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_err_q, par_err_d;
  logic                frame_err_q, frame_err_d;
  logic                last_stop_q, last_stop_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_par_q, out_par_d;
  logic                out_frame_q, out_frame_d;

  logic                tick_end;
  logic                par_xor;
  logic                par_bad;

  assign tick_end = i_tick && (tick_q == TICK_END);
  assign par_xor  = (^data_q) ^ rx_s_q;

  // odd mode wants an odd total count of ones, even mode an even count
  always_comb begin
    par_bad = 1'b0;
    if (PARITY == 1) begin
      par_bad = ~par_xor;
    end else if (PARITY == 2) begin
      par_bad = par_xor;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    data_d      = data_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    last_stop_d = last_stop_q;
    out_data_d  = out_data_q;
    out_par_d   = out_par_q;
    out_frame_d = out_frame_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          tick_d      = '0;
          bit_d       = '0;
          par_err_d   = 1'b0;
          frame_err_d = 1'b0;
          state_d     = S_START;
        end
      end

      S_START: begin
        if (i_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (!rx_s_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + TCW'(1);
          end
        end
      end

      S_DATA: begin
        if (i_tick) begin
          if (tick_end) begin
            tick_d = '0;
            data_d = {rx_s_q, data_q[DATA_W-1:1]};
            if (bit_q == BIT_END) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + BCW'(1);
            end
          end else begin
            tick_d = tick_q + TCW'(1);
          end
        end
      end

      S_PARITY: begin
        if (i_tick) begin
          if (tick_end) begin
            tick_d    = '0;
            par_err_d = par_bad;
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + TCW'(1);
          end
        end
      end

      S_STOP: begin
        if (i_tick) begin
          if (tick_end) begin
            tick_d = '0;
            if (!rx_s_q) begin
              frame_err_d = 1'b1;
            end
            if (bit_q == STOP_END) begin
              // outputs load on the DONE entry edge so they are valid with o_rcv
              bit_d       = '0;
              last_stop_d = rx_s_q;
              out_data_d  = data_q;
              out_par_d   = par_err_q;
              out_frame_d = frame_err_q | ~rx_s_q;
              state_d     = S_DONE;
            end else begin
              bit_d = bit_q + BCW'(1);
            end
          end else begin
            tick_d = tick_q + TCW'(1);
          end
        end
      end

      S_DONE: begin
        state_d = last_stop_q ? S_IDLE : S_BREAK;
      end

      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_q      <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      last_stop_q <= 1'b1;
      out_data_q  <= '0;
      out_par_q   <= 1'b0;
      out_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= i_rx;
      rx_s_q      <= rx_meta_q;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      last_stop_q <= last_stop_d;
      out_data_q  <= out_data_d;
      out_par_q   <= out_par_d;
      out_frame_q <= out_frame_d;
    end
  end

  assign o_data       = out_data_q;
  assign o_parity_err = out_par_q;
  assign o_frame_err  = out_frame_q;
  assign o_rcv        = (state_q == S_DONE);
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: four configurations (8N1, 8E1, 8N2, 7N1 with slow
// ticks) driven by a bit-level line driver and checked through a scoreboard.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic [3:0] rst_v;
  logic [3:0] rx_v;
  logic       tick3;
  int         tdiv = 0;

  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] rcv_v, perr_v, ferr_v, busy_v;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       par_bit;
    logic [1:0] stops;
    logic       exp_perr;
    logic       exp_ferr;
    string      name;
  } vec_t;

  exp_t sbq0[$];
  exp_t sbq1[$];
  exp_t sbq2[$];
  exp_t sbq3[$];
  vec_t vecs[10];

  uart_rx_fsm u0 (
    .clk(clk), .rst(rst_v[0]), .i_rx(rx_v[0]), .i_tick(1'b1),
    .o_data(d0), .o_rcv(rcv_v[0]), .o_parity_err(perr_v[0]),
    .o_frame_err(ferr_v[0]), .o_busy(busy_v[0])
  );

  uart_rx_fsm #(.PARITY(2)) u1 (
    .clk(clk), .rst(rst_v[1]), .i_rx(rx_v[1]), .i_tick(1'b1),
    .o_data(d1), .o_rcv(rcv_v[1]), .o_parity_err(perr_v[1]),
    .o_frame_err(ferr_v[1]), .o_busy(busy_v[1])
  );

  uart_rx_fsm #(.STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst_v[2]), .i_rx(rx_v[2]), .i_tick(1'b1),
    .o_data(d2), .o_rcv(rcv_v[2]), .o_parity_err(perr_v[2]),
    .o_frame_err(ferr_v[2]), .o_busy(busy_v[2])
  );

  uart_rx_fsm #(.DATA_W(7), .OVS(8)) u3 (
    .clk(clk), .rst(rst_v[3]), .i_rx(rx_v[3]), .i_tick(tick3),
    .o_data(d3), .o_rcv(rcv_v[3]), .o_parity_err(perr_v[3]),
    .o_frame_err(ferr_v[3]), .o_busy(busy_v[3])
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) tdiv <= (tdiv == 2) ? 0 : tdiv + 1;
  assign tick3 = (tdiv == 2);

  function automatic int dw(input int k);
    return (k == 3) ? 7 : 8;
  endfunction

  function automatic int bit_clks(input int k);
    return (k == 3) ? 24 : 16;
  endfunction

  function automatic logic [8:0] act_data(input int k);
    case (k)
      0: return {1'b0, d0};
      1: return {1'b0, d1};
      2: return {1'b0, d2};
      default: return {2'b00, d3};
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return sbq0.size();
      1: return sbq1.size();
      2: return sbq2.size();
      default: return sbq3.size();
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [8:0] data, input logic perr, input logic ferr);
    exp_t e;
    e.data = data & 9'((1 << dw(k)) - 1);
    e.perr = perr;
    e.ferr = ferr;
    case (k)
      0: sbq0.push_back(e);
      1: sbq1.push_back(e);
      2: sbq2.push_back(e);
      default: sbq3.push_back(e);
    endcase
  endtask

  task automatic pop_check(input int k);
    exp_t e;
    if (qsize(k) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_rcv inst%0d: o_rcv=1 required 0", k);
    end else begin
      case (k)
        0: e = sbq0.pop_front();
        1: e = sbq1.pop_front();
        2: e = sbq2.pop_front();
        default: e = sbq3.pop_front();
      endcase
      chk($sformatf("rcv_data inst%0d", k), 32'(act_data(k)), 32'(e.data));
      chk($sformatf("rcv_perr inst%0d", k), 32'(perr_v[k]), 32'(e.perr));
      chk($sformatf("rcv_ferr inst%0d", k), 32'(ferr_v[k]), 32'(e.ferr));
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rcv_v[k]) pop_check(k);
    end
  end

  task automatic drive_bit(input int k, input logic v, input int n);
    rx_v[k] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int k, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stops, input logic end_level);
    int bc = bit_clks(k);
    drive_bit(k, 1'b0, bc);
    for (int i = 0; i < dw(k); i++) drive_bit(k, data[i], bc);
    if (k == 1) drive_bit(k, par_bit, bc);
    for (int s = 0; s < ((k == 2) ? 2 : 1); s++) drive_bit(k, stops[s], bc);
    rx_v[k] = end_level;
  endtask

  task automatic wait_drain(input int k, input string name);
    int cyc = 0;
    while (qsize(k) != 0 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    n_cmp++;
    if (qsize(k) != 0) begin
      n_bad++;
      $display("FAIL %s: o_rcv missing, pending=%0d required 0", name, qsize(k));
      case (k)
        0: sbq0.delete();
        1: sbq1.delete();
        2: sbq2.delete();
        default: sbq3.delete();
      endcase
    end
  endtask

  task automatic set_vec(input int i, input int inst, input logic [8:0] data, input logic par_bit,
                         input logic [1:0] stops, input logic perr, input logic ferr, input string name);
    vecs[i].inst     = inst;
    vecs[i].data     = data;
    vecs[i].par_bit  = par_bit;
    vecs[i].stops    = stops;
    vecs[i].exp_perr = perr;
    vecs[i].exp_ferr = ferr;
    vecs[i].name     = name;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // stops[0] is the first stop bit on the line, stops[1] the second
    set_vec(0, 0, 9'h000, 1'b0, 2'b11, 1'b0, 1'b0, "8n1_00");
    set_vec(1, 0, 9'h0FF, 1'b0, 2'b11, 1'b0, 1'b0, "8n1_ff");
    set_vec(2, 0, 9'h096, 1'b0, 2'b10, 1'b0, 1'b1, "8n1_stop_low");
    set_vec(3, 1, 9'h003, 1'b1, 2'b11, 1'b1, 1'b0, "8e1_03_bad_par");
    set_vec(4, 1, 9'h003, 1'b0, 2'b11, 1'b0, 1'b0, "8e1_03_good_par");
    set_vec(5, 1, 9'h080, 1'b1, 2'b11, 1'b0, 1'b0, "8e1_80_good_par");
    set_vec(6, 1, 9'h07E, 1'b1, 2'b11, 1'b1, 1'b0, "8e1_7e_bad_par");
    set_vec(7, 2, 9'h0C3, 1'b0, 2'b11, 1'b0, 1'b0, "8n2_c3");
    set_vec(8, 2, 9'h05A, 1'b0, 2'b01, 1'b0, 1'b1, "8n2_second_stop_low");
    set_vec(9, 3, 9'h015, 1'b0, 2'b11, 1'b0, 1'b0, "7n1_15");

    rst_v = 4'hF;
    rx_v  = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst_v = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_data inst%0d", k), 32'(act_data(k)), 32'd0);
      chk($sformatf("reset_busy inst%0d", k), 32'(busy_v[k]), 32'd0);
      chk($sformatf("reset_flags inst%0d", k), 32'({rcv_v[k], perr_v[k], ferr_v[k]}), 32'd0);
    end

    // 8N1 frame 0xA5 with latency and post-DONE busy check
    push(0, 9'h0A5, 1'b0, 1'b0);
    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
      begin
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!rcv_v[0] && cyc < 400);
        chk("t1_rcv_seen", 32'(rcv_v[0]), 32'd1);
        chk("t1_latency_in_window", 32'((cyc - 1) >= 154 && (cyc - 1) <= 157), 32'd1);
        @(negedge clk);
        chk("t1_busy_after_done", 32'(busy_v[0]), 32'd0);
      end
    join
    wait_drain(0, "t1_drain");
    drive_bit(0, 1'b1, 32);

    // short low glitch must be rejected at the mid-bit sample
    drive_bit(0, 1'b0, 5);
    chk("t2_busy_in_start", 32'(busy_v[0]), 32'd1);
    drive_bit(0, 1'b1, 40);
    chk("t2_busy_after_glitch", 32'(busy_v[0]), 32'd0);
    chk("t2_data_held", 32'(d0), 32'h0A5);

    for (int i = 0; i < 10; i++) begin
      push(vecs[i].inst, vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
      send_frame(vecs[i].inst, vecs[i].data, vecs[i].par_bit, vecs[i].stops, 1'b1);
      wait_drain(vecs[i].inst, vecs[i].name);
      drive_bit(vecs[i].inst, 1'b1, 2 * bit_clks(vecs[i].inst));
    end

    // second stop low then line held low: BREAK until the line returns high
    push(2, 9'h081, 1'b0, 1'b1);
    send_frame(2, 9'h081, 1'b0, 2'b01, 1'b0);
    wait_drain(2, "t4_drain");
    drive_bit(2, 1'b0, 40);
    chk("t4_busy_in_break", 32'(busy_v[2]), 32'd1);
    chk("t4_ferr_held", 32'(ferr_v[2]), 32'd1);
    drive_bit(2, 1'b1, 10);
    chk("t4_busy_after_release", 32'(busy_v[2]), 32'd0);

    // 7-bit, OVS=8, tick every third clock, back-to-back frames
    push(3, 9'h055, 1'b0, 1'b0);
    push(3, 9'h02A, 1'b0, 1'b0);
    send_frame(3, 9'h055, 1'b0, 2'b11, 1'b1);
    send_frame(3, 9'h02A, 1'b0, 2'b11, 1'b1);
    wait_drain(3, "t5_drain");
    drive_bit(3, 1'b1, 48);

    // reset during data bit 4 aborts the frame
    drive_bit(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 16);
    drive_bit(0, 1'b0, 8);
    chk("t6_busy_before_rst", 32'(busy_v[0]), 32'd1);
    rst_v[0] = 1'b1;
    #1;
    chk("t6_data_on_rst", 32'(d0), 32'd0);
    chk("t6_flags_on_rst", 32'({rcv_v[0], perr_v[0], ferr_v[0], busy_v[0]}), 32'd0);
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    drive_bit(0, 1'b1, 300);
    chk("t6_idle_after_rst", 32'(busy_v[0]), 32'd0);
    push(0, 9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b1);
    wait_drain(0, "t6_drain");
    drive_bit(0, 1'b1, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
